irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: 16-source interrupt controller with per-source synchronizers,
// level/edge pending logic, mask, and a two-state single-cycle-ack bus port.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic [15:0] src,
    output logic [15:0] irq
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    localparam logic [1:0] A_PEND   = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_MODE   = 2'd2;
    localparam logic [1:0] A_ACTIVE = 2'd3;

    // Register read multiplexer shared by the bus capture path.
    function automatic logic [15:0] rd_mux(
        input logic [1:0]  a,
        input logic [15:0] pend,
        input logic [15:0] mask,
        input logic [15:0] mode
    );
        logic [15:0] v;
        case (a)
            A_PEND:   v = pend;
            A_MASK:   v = mask;
            A_MODE:   v = mode;
            A_ACTIVE: v = pend & mask;
            default:  v = 16'h0000;
        endcase
        return v;
    endfunction

    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] s_s;
    logic [15:0] s_d_q;
    logic [15:0] pend_q, pend_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] mode_q, mode_d;
    logic [15:0] irq_q;

    bus_state_e  state_q;
    logic        ack_q;
    logic [31:0] dout_q;
    logic        we_q;
    logic [1:0]  addr_q;
    logic [15:0] wdata_q;

    logic        wr_s;
    logic [15:0] w1c_s, w1s_s, mchg_s, edge_s, edge_pend_s;
    logic        unused_s;

    assign unused_s = ^data_in[31:16];
    assign s_s      = sync_q[SYNC_STAGES-1];
    assign data_out = dout_q;
    assign ack      = ack_q;
    assign irq      = irq_q;

    // Synchronizer chain: each source passes through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= 16'h0000;
            end
        end else begin
            sync_q[0] <= src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Next-state of PENDING/MASK/MODE; a write commits while leaving ACK.
    always_comb begin
        wr_s        = (state_q == ST_ACK) && we_q;
        w1c_s       = (wr_s && (addr_q == A_PEND))   ? wdata_q : 16'h0000;
        w1s_s       = (wr_s && (addr_q == A_ACTIVE)) ? wdata_q : 16'h0000;
        mchg_s      = (wr_s && (addr_q == A_MODE))   ? (wdata_q ^ mode_q) : 16'h0000;
        edge_s      = s_s & ~s_d_q;
        // Set (edge or W1S) dominates a same-cycle W1C.
        edge_pend_s = edge_s | w1s_s | (pend_q & ~w1c_s);
        // Level bits mirror the synchronized source; a mode flip clears the bit.
        pend_d      = ((mode_q & edge_pend_s) | (~mode_q & s_s)) & ~mchg_s;
        if (wr_s && (addr_q == A_MASK)) begin
            mask_d = wdata_q;
        end else begin
            mask_d = mask_q;
        end
        if (wr_s && (addr_q == A_MODE)) begin
            mode_d = wdata_q;
        end else begin
            mode_d = mode_q;
        end
    end

    // Interrupt state registers and the registered irq output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d_q  <= 16'h0000;
            pend_q <= 16'h0000;
            mask_q <= 16'h0000;
            mode_q <= 16'h0000;
            irq_q  <= 16'h0000;
        end else begin
            s_d_q  <= s_s;
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            irq_q  <= pend_q & mask_q;
        end
    end

    // Bus FSM: capture the access on entry to ACK, ack for one cycle, return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dout_q  <= 32'h0000_0000;
            we_q    <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stb) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        dout_q  <= {16'h0000, rd_mux(addr, pend_q, mask_q, mode_q)};
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= data_in[15:0];
                    end else begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                        dout_q  <= 32'h0000_0000;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dout_q  <= 32'h0000_0000;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dout_q  <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model of the interrupt controller.
module tb_irq_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [15:0] src;
    logic [15:0] irq;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .src      (src),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_hist [0:S];   // m_hist[k] = src as sampled k+1 edges ago
    logic [15:0] m_pend, m_mask, m_mode, m_irq;
    logic        m_busy, m_we;
    logic [1:0]  m_addr;
    logic [15:0] m_wd;
    logic [31:0] m_dout;

    function automatic logic [15:0] model_pend(
        input logic [15:0] pend, input logic [15:0] mode,
        input logic [15:0] s, input logic [15:0] sd,
        input logic wr, input logic [1:0] wa, input logic [15:0] wd
    );
        logic [15:0] n;
        for (int i = 0; i < 16; i++) begin
            if (mode[i] == 1'b0) begin
                n[i] = s[i];
            end else if ((s[i] && !sd[i]) || (wr && wa == 2'd3 && wd[i])) begin
                n[i] = 1'b1;
            end else if (wr && wa == 2'd0 && wd[i]) begin
                n[i] = 1'b0;
            end else begin
                n[i] = pend[i];
            end
            if (wr && wa == 2'd2 && (wd[i] != mode[i])) n[i] = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_pend;
            2'd1:    return m_mask;
            2'd2:    return m_mode;
            default: return m_pend & m_mask;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= S; k++) m_hist[k] <= 16'h0000;
            m_pend <= 16'h0000; m_mask <= 16'h0000; m_mode <= 16'h0000;
            m_irq  <= 16'h0000; m_busy <= 1'b0;     m_we   <= 1'b0;
            m_addr <= 2'd0;     m_wd   <= 16'h0000; m_dout <= 32'h0;
        end else begin
            m_pend <= model_pend(m_pend, m_mode, m_hist[S-1], m_hist[S],
                                 m_busy && m_we, m_addr, m_wd);
            if (m_busy && m_we && m_addr == 2'd1) m_mask <= m_wd;
            if (m_busy && m_we && m_addr == 2'd2) m_mode <= m_wd;
            m_irq <= m_pend & m_mask;
            m_hist[0] <= src;
            for (int k = 1; k <= S; k++) m_hist[k] <= m_hist[k-1];
            if (m_busy) begin
                m_busy <= 1'b0;
                m_dout <= 32'h0;
            end else if (stb) begin
                m_busy <= 1'b1;
                m_we   <= we;
                m_addr <= addr;
                m_wd   <= data_in[15:0];
                m_dout <= {16'h0000, model_read(addr)};
            end else begin
                m_dout <= 32'h0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check_val("ack",  {31'd0, ack}, {31'd0, m_busy});
        check_val("dout", data_out, m_dout);
        check_val("irq",  {16'h0000, irq}, {16'h0000, m_irq});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_access(input logic w, input logic [1:0] a, input logic [15:0] d,
                              output logic [31:0] rd);
        logic [31:0] r;
        r = $urandom;
        tick();
        stb = 1'b1; we = w; addr = a; data_in = {r[31:16], d};
        tick();
        rd = data_out;
        stb = 1'b0; we = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] rnd;

    initial begin
        rst = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0; src = 16'h0000;
        ticks(3);
        rst = 1'b1;
        ticks(2);

        // Reset state reads back as zero.
        for (int a = 0; a < 4; a++) begin
            bus_access(1'b0, a[1:0], 16'h0000, rd);
            check_val("reset_read", rd, 32'h0000_0000);
        end

        // Edge-mode source 0: fixed latency, sticky, W1C.
        bus_access(1'b1, 2'd2, 16'h0001, rd);
        bus_access(1'b1, 2'd1, 16'h0001, rd);
        src[0] = 1'b1;
        ticks(3);
        check_val("edge_lat3", {31'd0, irq[0]}, 32'd0);
        src[0] = 1'b0;
        tick();
        check_val("edge_lat4", {31'd0, irq[0]}, 32'd1);
        ticks(4);
        check_val("edge_sticky", {31'd0, irq[0]}, 32'd1);
        bus_access(1'b1, 2'd0, 16'h0001, rd);
        tick();
        check_val("w1c_1cyc", {31'd0, irq[0]}, 32'd1);
        tick();
        check_val("w1c_2cyc", {31'd0, irq[0]}, 32'd0);

        // Level-mode source 15: follows s, W1C ignored.
        bus_access(1'b1, 2'd2, 16'h0000, rd);
        bus_access(1'b1, 2'd1, 16'h8000, rd);
        src[15] = 1'b1;
        ticks(4);
        check_val("level_rise", {31'd0, irq[15]}, 32'd1);
        bus_access(1'b1, 2'd0, 16'h8000, rd);
        ticks(2);
        check_val("level_w1c_ign", {31'd0, irq[15]}, 32'd1);
        src[15] = 1'b0;
        ticks(3);
        check_val("level_fall3", {31'd0, irq[15]}, 32'd1);
        tick();
        check_val("level_fall4", {31'd0, irq[15]}, 32'd0);

        // Edge bit 3: W1C coinciding with a new rising edge keeps it pending.
        bus_access(1'b1, 2'd2, 16'h0008, rd);
        bus_access(1'b1, 2'd1, 16'h0008, rd);
        src[3] = 1'b1;
        ticks(4);
        check_val("b3_pend", {31'd0, irq[3]}, 32'd1);
        src[3] = 1'b0;
        ticks(4);
        src[3] = 1'b1;
        bus_access(1'b1, 2'd0, 16'h0008, rd);
        ticks(2);
        bus_access(1'b0, 2'd0, 16'h0000, rd);
        check_val("b3_set_wins", rd, 32'h0000_0008);
        src[3] = 1'b0;
        ticks(4);

        // W1S through ACTIVE, then a MODE write clears flipped bits.
        bus_access(1'b1, 2'd2, 16'h00F0, rd);
        bus_access(1'b1, 2'd1, 16'h0030, rd);
        bus_access(1'b1, 2'd3, 16'h00F0, rd);
        bus_access(1'b0, 2'd0, 16'h0000, rd);
        check_val("w1s_pend", rd, 32'h0000_00F0);
        ticks(2);
        check_val("w1s_irq", {16'h0000, irq}, 32'h0000_0030);
        bus_access(1'b0, 2'd3, 16'h0000, rd);
        check_val("active_rd", rd, 32'h0000_0030);
        bus_access(1'b1, 2'd2, 16'h0000, rd);
        bus_access(1'b0, 2'd0, 16'h0000, rd);
        check_val("mode_clr", rd, 32'h0000_0000);

        // Reset during a MASK write aborts it without ack.
        tick();
        stb = 1'b1; we = 1'b1; addr = 2'd1; data_in = 32'h0000_FFFF;
        #2 rst = 1'b0;
        ticks(2);
        stb = 1'b0; we = 1'b0;
        rst = 1'b1;
        tick();
        bus_access(1'b0, 2'd1, 16'h0000, rd);
        check_val("abort_mask", rd, 32'h0000_0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                stb = 1'b0;
                tick();
                rst = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) src = src ^ (16'h0001 << $urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                rnd = $urandom;
                src = rnd[15:0];
            end
            stb     = ($urandom_range(0, 2) == 0);
            we      = ($urandom_range(0, 1) == 0);
            rnd     = $urandom;
            addr    = rnd[1:0];
            data_in = $urandom;
        end
        stb = 1'b0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
